// File: rtl/jtkicker_dwnld_remap.sv
// Download remapper: rewrites ioctl bytes per address region and queues them
// as masked 16-bit SDRAM writes through a small FIFO with ack handshake.
module jtkicker_dwnld_remap #(
  parameter int          REGIONS    = 3,
  parameter logic [24:0] START0     = 25'h0,
  parameter logic [24:0] START1     = 25'h10000,
  parameter logic [24:0] START2     = 25'h18000,
  parameter logic [24:0] START3     = 25'h20000,
  parameter logic [1:0]  MODE0      = 2'd0,
  parameter logic [1:0]  MODE1      = 2'd0,
  parameter logic [1:0]  MODE2      = 2'd0,
  parameter logic [1:0]  MODE3      = 2'd0,
  parameter logic [24:0] PROM_START = 25'h28000,
  parameter int          FIFO_AW    = 2,
  parameter bit          SWAB       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [3:0][24:0] START_A = {START3, START2, START1, START0};
  // The last active region is closed by PROM_START instead of the next start.
  localparam logic [3:0][24:0] END_A = {
    PROM_START,
    (REGIONS == 3) ? PROM_START : START3,
    (REGIONS == 2) ? PROM_START : START2,
    (REGIONS == 1) ? PROM_START : START1
  };
  localparam logic [3:0][1:0] MODE_A = {MODE3, MODE2, MODE1, MODE0};

  logic [1:0]  w_mode;
  logic [24:0] w_base, w_off, w_shuf, w_addr;
  logic [7:0]  w_byte;
  logic        w_prom, w_accept;

  always_comb begin
    w_mode = 2'd0;
    w_base = 25'd0;
    for (int k = 0; k < 4; k++) begin
      if (k < REGIONS && ioctl_addr >= START_A[k] && ioctl_addr < END_A[k]) begin
        w_mode = MODE_A[k];
        w_base = START_A[k];
      end
    end
  end

  assign w_prom = ioctl_addr >= PROM_START;
  assign w_off  = ioctl_addr - w_base;

  // Object shuffle: only bits 0..6, 14 and 15 of the offset move.
  always_comb begin
    w_shuf      = w_off;
    w_shuf[15]  = w_off[0];
    w_shuf[14]  = w_off[15];
    w_shuf[0]   = ~w_off[14];
    w_shuf[2:1] = w_off[5:4] + 2'd1;
    w_shuf[6:3] = {w_off[6], w_off[3:1]};
  end

  always_comb begin
    w_addr = ioctl_addr;
    w_byte = ioctl_dout;
    case (w_mode)
      2'd1:    w_byte = {ioctl_dout[3:0], ioctl_dout[7:4]};
      2'd2:    w_addr = w_base + w_shuf;
      default: ;
    endcase
  end

  assign w_accept = ioctl_wr & downloading & (w_mode != 2'd3);

  logic        r_pipe_vld;
  logic [24:0] r_pipe_addr;
  logic [7:0]  r_pipe_byte;
  logic        r_pipe_prom;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld  <= 1'b0;
      r_pipe_addr <= 25'd0;
      r_pipe_byte <= 8'd0;
      r_pipe_prom <= 1'b0;
    end else begin
      r_pipe_vld <= w_accept;
      if (w_accept) begin
        r_pipe_addr <= w_addr;
        r_pipe_byte <= w_byte;
        r_pipe_prom <= w_prom;
      end
    end
  end

  logic [33:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_dl_prev, r_overflow;
  logic               w_nonempty, w_full, w_push, w_pop;
  logic [33:0]        w_head;
  logic [24:0]        w_head_addr;
  logic [7:0]         w_head_byte;
  logic               w_head_prom, w_unused;

  assign w_nonempty = r_count != '0;
  assign w_full     = r_count == FULL_CNT;
  assign w_pop      = w_nonempty & sdram_ack;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_push     = r_pipe_vld & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pipe_prom, r_pipe_byte, r_pipe_addr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_dl_prev  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_count   <= r_count + (FIFO_AW + 1)'(w_push) - (FIFO_AW + 1)'(w_pop);
      r_dl_prev <= downloading;
      if (downloading && !r_dl_prev)
        r_overflow <= 1'b0;
      else if (r_pipe_vld && w_full && !w_pop)
        r_overflow <= 1'b1;
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_addr = w_head[24:0];
  assign w_head_byte = w_head[32:25];
  assign w_head_prom = w_head[33];
  assign w_unused    = ^w_head_addr[24:23];

  assign prog_we   = w_nonempty;
  assign prom_we   = w_nonempty & w_head_prom;
  assign prog_addr = w_nonempty ? w_head_addr[22:1] : 22'd0;
  assign prog_data = w_nonempty ? {w_head_byte, w_head_byte} : 16'd0;
  assign prog_mask = !w_nonempty ? 2'b11 :
                     ((w_head_addr[0] ^ SWAB) ? 2'b01 : 2'b10);
  assign busy      = rst_n & (downloading | r_pipe_vld | w_nonempty);
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_jtkicker_dwnld_remap.sv
// Bench for jtkicker_dwnld_remap: queue-based reference model compared every
// cycle, plus directed literal checks on remap, back-pressure and reset.
module tb_jtkicker_dwnld_remap;

  logic        clk = 1'b0, rst_n = 1'b1, downloading = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wr = 1'b0, sdram_ack = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, prom_we, busy, overflow;

  always #5 clk = ~clk;

  // Region map: r0 pass, r1 shuffle, r2 nibble swap, r3 drop.
  jtkicker_dwnld_remap #(
    .REGIONS(4), .START0(25'h0), .START1(25'h10000), .START2(25'h18000),
    .START3(25'h20000), .MODE0(2'd0), .MODE1(2'd2), .MODE2(2'd1), .MODE3(2'd3),
    .PROM_START(25'h28000), .FIFO_AW(2), .SWAB(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prom_we(prom_we), .sdram_ack(sdram_ack),
    .busy(busy), .overflow(overflow)
  );

  typedef struct { logic [24:0] addr; logic [7:0] b; logic prom; } ent_t;

  ent_t m_q[$];
  ent_t m_pipe, e_c, h_c;
  bit   m_pipe_vld = 0, m_ovf = 0, m_dl_prev = 0;
  bit   pop_c, full_c, drop_c;
  int   n_checks = 0, n_fail = 0;
  longint x_addr, x_data, x_mask, x_we, x_prom, x_busy;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void remap(input logic [24:0] a, input logic [7:0] d,
                                output bit drop, output ent_t e);
    int unsigned ad, base, o, op, mode;
    ad = a; mode = 0; base = 0; drop = 0;
    if (ad >= 'h10000 && ad < 'h18000) begin mode = 2; base = 'h10000; end
    else if (ad >= 'h18000 && ad < 'h20000) begin mode = 1; base = 'h18000; end
    else if (ad >= 'h20000 && ad < 'h28000) mode = 3;
    e.addr = a; e.b = d; e.prom = (ad >= 'h28000);
    if (mode == 1) e.b = 8'(((d * 16) + (d / 16)) & 'hFF);
    if (mode == 2) begin
      o  = ad - base;
      op = (o & ~32'hC07F) | ((o % 2) << 15) | (((o >> 15) % 2) << 14)
         | (1 - (o >> 14) % 2) | ((((o >> 4) + 1) % 4) << 1)
         | (((o >> 6) % 2) << 6) | (((o >> 1) % 8) << 3);
      e.addr = 25'(base + op);
    end
    if (mode == 3) drop = 1;
  endfunction

  // Reference model: one step per clock edge.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_q.delete(); m_pipe_vld = 0; m_ovf = 0; m_dl_prev = 0;
    end else begin
      full_c = (m_q.size() == 4);
      pop_c  = (m_q.size() > 0) && sdram_ack;
      if (pop_c) void'(m_q.pop_front());
      if (m_pipe_vld) begin
        if (!full_c || pop_c) m_q.push_back(m_pipe);
        else m_ovf = 1;
      end
      if (downloading && !m_dl_prev) m_ovf = 0;
      m_dl_prev = downloading;
      m_pipe_vld = 0;
      if (ioctl_wr && downloading) begin
        remap(ioctl_addr, ioctl_dout, drop_c, e_c);
        if (!drop_c) begin m_pipe_vld = 1; m_pipe = e_c; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    x_we = (m_q.size() > 0);
    x_addr = 0; x_data = 0; x_mask = 3; x_prom = 0;
    if (x_we != 0) begin
      h_c    = m_q[0];
      x_addr = longint'(h_c.addr) / 2 % 'h400000;
      x_data = longint'(h_c.b) * 257;
      x_mask = (h_c.addr % 2 == 1) ? 2 : 1;
      x_prom = h_c.prom;
    end
    x_busy = (rst_n && (downloading || m_pipe_vld || m_q.size() > 0)) ? 1 : 0;
    chk("cmp_prog_we", prog_we, x_we);
    chk("cmp_prom_we", prom_we, x_prom);
    chk("cmp_prog_addr", prog_addr, x_addr);
    chk("cmp_prog_data", prog_data, x_data);
    chk("cmp_prog_mask", prog_mask, x_mask);
    chk("cmp_busy", busy, x_busy);
    chk("cmp_overflow", overflow, m_ovf);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic pop1();
    sdram_ack = 1'b1; step(); sdram_ack = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0; sdram_ack = 1'b1;
    repeat (8) begin
      if (prog_we) n++;
      step();
    end
    sdram_ack = 1'b0;
  endtask

  logic [24:0] bnd [6] = '{25'h0FFFF, 25'h10000, 25'h17FFF, 25'h18000, 25'h1FFFF, 25'h28000};
  int n_drained;

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_prog_we", prog_we, 0);
    chk("rst_prog_mask", prog_mask, 2'b11);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();
    downloading = 1'b1;
    step();

    // Nibble swap region, hold without ack
    wr_byte(25'h18000, 8'hA5);
    chk("m1_latency_n1", prog_we, 0);
    step();
    chk("m1_prog_we", prog_we, 1);
    chk("m1_prog_data", prog_data, 16'h5A5A);
    chk("m1_prog_addr", prog_addr, 22'hC000);
    chk("m1_prog_mask", prog_mask, 2'b01);
    repeat (5) begin
      step();
      chk("m1_hold_data", prog_data, 16'h5A5A);
      chk("m1_hold_addr", prog_addr, 22'hC000);
    end
    pop1();
    chk("m1_popped", prog_we, 0);

    // Shuffle region
    wr_byte(25'h10001, 8'h11); step();
    chk("m2_off1_addr", prog_addr, 22'hC001);
    chk("m2_off1_mask", prog_mask, 2'b10);
    pop1();
    wr_byte(25'h14000, 8'h22); step();
    chk("m2_off4000_addr", prog_addr, 22'h8001);
    chk("m2_off4000_mask", prog_mask, 2'b01);
    pop1();
    wr_byte(25'h10000, 8'h23); step();
    chk("m2_off0_addr", prog_addr, 22'h8001);
    chk("m2_off0_mask", prog_mask, 2'b10);
    pop1();
    wr_byte(25'h17FFF, 8'h24); step();
    chk("m2_last_addr", prog_addr, 22'hDFFC);
    pop1();

    // Pass region and PROM
    wr_byte(25'h00123, 8'h77); step();
    chk("m0_addr", prog_addr, 22'h91);
    chk("m0_data", prog_data, 16'h7777);
    chk("m0_mask", prog_mask, 2'b10);
    pop1();
    wr_byte(25'h28003, 8'h3C); step();
    chk("prom_we", prom_we, 1);
    chk("prom_prog_we", prog_we, 1);
    chk("prom_mask", prog_mask, 2'b10);
    chk("prom_addr", prog_addr, 22'h14001);
    pop1();
    chk("prom_we_after", prom_we, 0);

    foreach (bnd[i]) begin
      wr_byte(bnd[i], 8'(8'h40 + i)); step(); pop1();
    end

    // Writes while not downloading are ignored
    downloading = 1'b0;
    wr_byte(25'h00100, 8'h55); step(); step();
    chk("idle_wr_prog_we", prog_we, 0);
    chk("idle_wr_busy", busy, 0);
    downloading = 1'b1;
    step();

    // Back-pressure
    for (int i = 0; i < 5; i++) wr_byte(25'(i * 2), 8'(i + 1));
    step();
    chk("bp_overflow_set", overflow, 1);
    downloading = 1'b0; step();
    downloading = 1'b1; step();
    chk("bp_overflow_clr", overflow, 0);
    chk("bp_no_flush", prog_we, 1);
    ioctl_addr = 25'h40; ioctl_dout = 8'hEE; ioctl_wr = 1'b1;
    step();
    ioctl_wr = 1'b0; sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    chk("bp_full_pushpop_ovf", overflow, 0);
    drain(n_drained);
    chk("bp_occupancy", n_drained, 4);

    // Reset with queued entries
    wr_byte(25'h200, 8'h01); wr_byte(25'h201, 8'h02); wr_byte(25'h202, 8'h03);
    step();
    chk("rq_prog_we", prog_we, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rq_rst_prog_we", prog_we, 0);
    chk("rq_rst_prom_we", prom_we, 0);
    chk("rq_rst_busy", busy, 0);
    chk("rq_rst_overflow", overflow, 0);
    chk("rq_rst_addr", prog_addr, 0);
    chk("rq_rst_data", prog_data, 0);
    chk("rq_rst_mask", prog_mask, 2'b11);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rq_no_we_after", prog_we, 0);
    wr_byte(25'h300, 8'h99);
    chk("rq_latency_n1", prog_we, 0);
    step();
    chk("rq_latency_n2", prog_we, 1);
    chk("rq_data", prog_data, 16'h9999);
    pop1();

    // Drop region
    wr_byte(25'h20010, 8'h12);
    wr_byte(25'h27FFF, 8'h34);
    chk("m3_prog_we", prog_we, 0);
    step();
    chk("m3_prog_we2", prog_we, 0);
    downloading = 1'b0;
    step(); step();
    chk("m3_busy_fall", busy, 0);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
